// File: rtl/abus_pkg.sv
// Shared abus definitions: access-field width helper, slave FSM states, wait counter width.
// Latency: none; types, constants and a constant function only.
// Backpressure: not applicable.
package abus_pkg;

    // Wait-state counters cover 0..255 cycles.
    localparam int ABUS_WAIT_W = 8;

    // Width of strb/keep: both must be able to express the value DATA_WIDTH itself.
    function automatic int sk_size(input int dw);
        return $clog2(dw + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } abus_slv_state_t;

endpackage

// File: rtl/abus_bit_mask.sv
// Combinational bit mask: bits [strb, min(strb+keep, DATA_WIDTH)) set; keep saturates at DATA_WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; keep=0 or strb>=DATA_WIDTH yields an all-zero mask.
module abus_bit_mask
    import abus_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SK_SIZE    = sk_size(DATA_WIDTH)
) (
    input  logic [SK_SIZE-1:0]    i_strb,
    input  logic [SK_SIZE-1:0]    i_keep,
    output logic [DATA_WIDTH-1:0] o_mask
);

    // Each bit is set when it lies inside the half-open window starting at strb.
    always_comb begin
        int w_lo;
        int w_hi;
        o_mask = '0;
        w_lo   = int'(i_strb);
        w_hi   = w_lo + ((int'(i_keep) > DATA_WIDTH) ? DATA_WIDTH : int'(i_keep));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_mask[i] = (i >= w_lo) && (i < w_hi);
        end
    end

endmodule

// File: rtl/abus_sram_slave.sv
// abus slave memory: window decode with error ack, separate rd/wr wait states, bit-granular masking.
// Latency: request sampled in IDLE at cycle N -> one-cycle sack at N+1+wait states.
// Backpressure: requests held until sack; sabort drops a pending access; ABUS_SRAM_PARITY_EN adds per-word even parity.
module abus_sram_slave
    import abus_pkg::*;
#(
    parameter int START_ADDR    = 0,
    parameter int SIZE          = 512,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_WAIT_STATE = 1,
    parameter int WR_WAIT_STATE = 1
) (
    input  logic                            abus_clk,
    input  logic                            abus_rstb,
    input  logic                            abus_swrite,
    input  logic                            abus_sread,
    input  logic                            abus_sabort,
    input  logic [ADDR_WIDTH-1:0]           abus_saddress,
    input  logic [DATA_WIDTH-1:0]           abus_swdata,
    input  logic [sk_size(DATA_WIDTH)-1:0]  abus_sstrb,
    input  logic [sk_size(DATA_WIDTH)-1:0]  abus_skeep,
    output logic                            abus_sack,
    output logic [DATA_WIDTH-1:0]           abus_srdata,
    output logic                            abus_serr
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    abus_slv_state_t         r_state;
    logic [ABUS_WAIT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic                    r_rd;
    logic                    r_err;
    logic                    r_sack;
    logic                    r_serr;
    logic [DATA_WIDTH-1:0]   r_srdata;
    logic [DATA_WIDTH-1:0]   r_mem [SIZE];

    logic [DATA_WIDTH-1:0]   w_live_mask;
    logic                    w_live_err;
    logic [IDX_W-1:0]        w_live_idx;
    logic                    w_start;
    logic [ABUS_WAIT_W-1:0]  w_wait_ld;
    logic                    w_in_idle;
    logic [IDX_W-1:0]        w_acc_idx;
    logic [DATA_WIDTH-1:0]   w_acc_mask;
    logic [DATA_WIDTH-1:0]   w_acc_wdata;
    logic                    w_acc_rd;
    logic                    w_acc_err;
    logic                    w_enter_ack;
    logic                    w_commit;
    logic [DATA_WIDTH-1:0]   w_mem_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_par_bad;

    abus_bit_mask #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mask (
        .i_strb (abus_sstrb),
        .i_keep (abus_skeep),
        .o_mask (w_live_mask)
    );

    // Decode and access selection: in IDLE the live bus is used (zero-wait path), otherwise the latched copy.
    always_comb begin
        w_live_err  = (32'(abus_saddress) < 32'(START_ADDR))
                   || (32'(abus_saddress) >= 32'(START_ADDR + SIZE))
                   || (abus_swrite && abus_sread);
        w_live_idx  = IDX_W'(32'(abus_saddress) - 32'(START_ADDR));
        w_start     = (abus_swrite || abus_sread) && !abus_sabort;
        w_wait_ld   = abus_sread ? ABUS_WAIT_W'(RD_WAIT_STATE) : ABUS_WAIT_W'(WR_WAIT_STATE);
        w_in_idle   = (r_state == IDLE);
        w_acc_idx   = w_in_idle ? w_live_idx  : r_idx;
        w_acc_mask  = w_in_idle ? w_live_mask : r_mask;
        w_acc_wdata = w_in_idle ? abus_swdata : r_wdata;
        w_acc_rd    = w_in_idle ? abus_sread  : r_rd;
        w_acc_err   = w_in_idle ? w_live_err  : r_err;
        w_enter_ack = (w_in_idle && w_start && (w_wait_ld == '0))
                   || ((r_state == WAIT) && !abus_sabort && (r_cnt <= ABUS_WAIT_W'(1)));
        // Reset gating keeps an in-flight write from landing while the FSM is being cleared.
        w_commit    = w_enter_ack && !w_acc_rd && !w_acc_err && abus_rstb;
        w_mem_word  = r_mem[w_acc_idx];
        w_merged    = (w_mem_word & ~w_acc_mask) | (w_acc_wdata & w_acc_mask);
    end

`ifdef ABUS_SRAM_PARITY_EN
    logic r_par [SIZE];

    // A stored word whose even parity no longer matches is reported on read.
    always_comb begin
        w_par_bad = (^w_mem_word) != r_par[w_acc_idx];
    end

    // Memory and parity update on the edge entering ACK; parity covers the merged word.
    always_ff @(posedge abus_clk) begin
        if (w_commit) begin
            r_mem[w_acc_idx] <= w_merged;
            r_par[w_acc_idx] <= ^w_merged;
        end
    end
`else
    // No parity storage in this build.
    always_comb begin
        w_par_bad = 1'b0;
    end

    // Memory update on the edge entering ACK; contents are deliberately not reset.
    always_ff @(posedge abus_clk) begin
        if (w_commit) begin
            r_mem[w_acc_idx] <= w_merged;
        end
    end
`endif

    // Access FSM with registered ack/data/error outputs, valid only in the ACK cycle.
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_mask   <= '0;
            r_rd     <= 1'b0;
            r_err    <= 1'b0;
            r_sack   <= 1'b0;
            r_serr   <= 1'b0;
            r_srdata <= '0;
        end else begin
            r_sack   <= 1'b0;
            r_serr   <= 1'b0;
            r_srdata <= '0;
            if (w_enter_ack) begin
                r_sack   <= 1'b1;
                r_serr   <= w_acc_err || (w_acc_rd && w_par_bad);
                r_srdata <= (w_acc_rd && !w_acc_err) ? (w_mem_word & w_acc_mask) : '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_idx   <= w_live_idx;
                        r_wdata <= abus_swdata;
                        r_mask  <= w_live_mask;
                        r_rd    <= abus_sread;
                        r_err   <= w_live_err;
                        r_cnt   <= w_wait_ld;
                        r_state <= (w_wait_ld == '0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (abus_sabort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt <= ABUS_WAIT_W'(1)) begin
                        r_state <= ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - ABUS_WAIT_W'(1);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign abus_sack   = r_sack;
    assign abus_serr   = r_serr;
    assign abus_srdata = r_srdata;

endmodule
